des_perm_pipe: RTL and testbench

DES_PERM_PIPE -- requirements
Module: des_perm_pipe

---
 rtl/des_perm_pipe_if.sv | 40 ++++
 rtl/des_perm_pipe.sv | 127 ++++++++++++
 tb/tb_des_perm_pipe.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_perm_pipe_if.sv
// Handshake bus for des_perm_pipe; signal names are from the pipeline's point of view.
// The slave modport is the pipeline, the master modport is the upstream/downstream environment.
interface des_perm_pipe_if #(
    parameter int LANES = 1,
    parameter int CNT_W = 16
);
    logic                  valid_i;
    logic                  ready_o;
    logic                  mode_i;
    logic [64*LANES-1:0]   data_i;
    logic                  valid_o;
    logic                  ready_i;
    logic                  mode_o;
    logic [64*LANES-1:0]   data_o;
    logic [CNT_W-1:0]      blk_cnt_o;

    modport slave (
        input  valid_i,
        input  mode_i,
        input  data_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output mode_o,
        output data_o,
        output blk_cnt_o
    );

    modport master (
        output valid_i,
        output mode_i,
        output data_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  mode_o,
        input  data_o,
        input  blk_cnt_o
    );
endinterface

// File: rtl/des_perm_pipe.sv
// DES initial permutation (IP) / inverse (IP^-1) applied per 64-bit lane, followed by a
// DEPTH-stage valid/ready pipeline with bubble collapsing and an output transfer counter.
module des_perm_pipe #(
    parameter int LANES = 1,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    des_perm_pipe_if.slave  pipe_if
);

    localparam int W = 64 * LANES;

    // FIPS bit n (1 = MSB) lives at vector index 64-n.
    function automatic logic [63:0] des_perm(input logic [63:0] x, input logic inv);
        logic [63:0] y;
        int unsigned src;
        logic [5:0]  dst_idx;
        logic [5:0]  src_idx;
        y = '0;
        for (int unsigned r = 0; r < 8; r++) begin
            for (int unsigned c = 0; c < 8; c++) begin
                if (!inv) begin
                    src = (r < 4) ? (58 + 2 * r - 8 * c) : (57 + 2 * (r - 4) - 8 * c);
                end else begin
                    case (c)
                        0:       src = 40 - r;
                        1:       src = 8 - r;
                        2:       src = 48 - r;
                        3:       src = 16 - r;
                        4:       src = 56 - r;
                        5:       src = 24 - r;
                        6:       src = 64 - r;
                        default: src = 32 - r;
                    endcase
                end
                dst_idx    = 6'(63 - 8 * r - c);
                src_idx    = 6'(64 - src);
                y[dst_idx] = x[src_idx];
            end
        end
        return y;
    endfunction

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] mode_q, mode_d;
    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q;

    logic [DEPTH-1:0] adv;
    logic [W-1:0]     perm_data;
    logic             ready;
    logic             in_fire;
    logic             out_fire;

    // Stage k advances if ready_i is high or any stage at or after k is empty.
    always_comb begin : advance_chain
        logic acc;
        acc = pipe_if.ready_i;
        adv = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            acc                = acc | ~valid_q[DEPTH-1-i];
            adv[DEPTH-1-i]     = acc;
        end
    end

    assign ready    = run_q & adv[0];
    assign in_fire  = pipe_if.valid_i & ready;
    assign out_fire = valid_q[DEPTH-1] & pipe_if.ready_i;

    always_comb begin
        perm_data = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            perm_data[64*l +: 64] = des_perm(pipe_if.data_i[64*l +: 64], pipe_if.mode_i);
        end
    end

    always_comb begin
        valid_d = valid_q;
        mode_d  = mode_q;
        data_d  = data_q;
        cnt_d   = cnt_q + CNT_W'(out_fire);
        if (adv[0]) begin
            valid_d[0] = in_fire;
            mode_d[0]  = pipe_if.mode_i;
            data_d[0]  = perm_data;
        end
        for (int unsigned k = 1; k < DEPTH; k++) begin
            if (adv[k]) begin
                valid_d[k] = valid_q[k-1];
                mode_d[k]  = mode_q[k-1];
                data_d[k]  = data_q[k-1];
            end
        end
    end

    // run_q holds ready_o low until the first edge that samples rst_ni high.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign pipe_if.ready_o   = ready;
    assign pipe_if.valid_o   = valid_q[DEPTH-1];
    assign pipe_if.mode_o    = mode_q[DEPTH-1];
    assign pipe_if.data_o    = data_q[DEPTH-1];
    assign pipe_if.blk_cnt_o = cnt_q;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed bench for des_perm_pipe: one single-lane DEPTH=2/CNT_W=4 instance and one
// two-lane DEPTH=3 instance, checked against hand-computed DES IP / IP^-1 vectors.
module tb_des_perm_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    des_perm_pipe_if #(.LANES(1), .CNT_W(4))  ifa ();
    des_perm_pipe_if #(.LANES(2), .CNT_W(16)) ifb ();

    des_perm_pipe #(.LANES(1), .DEPTH(2), .CNT_W(4)) u_a (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .pipe_if (ifa)
    );

    des_perm_pipe #(.LANES(2), .DEPTH(3), .CNT_W(16)) u_b (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .pipe_if (ifb)
    );

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [63:0] P0   = 64'h0123456789ABCDEF;
    localparam logic [63:0] P1   = 64'hCC00CCFFF0AAF0AA;  // IP(P0)
    localparam logic [63:0] P2   = 64'h5D580D08FDF8ADA8;  // IP(P1)
    localparam logic [63:0] B1   = 64'h8000000000000000;  // FIPS bit 1
    localparam logic [63:0] B58  = 64'h0000000000000040;  // IP^-1(B1): bit 58
    localparam logic [63:0] B40  = 64'h0000000001000000;  // IP(B1): bit 40
    localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout expected=finish");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.valid_i = 1'b0; ifa.mode_i = 1'b0; ifa.data_i = '0; ifa.ready_i = 1'b1;
        ifb.valid_i = 1'b0; ifb.mode_i = 1'b0; ifb.data_i = '0; ifb.ready_i = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (ifa.valid_o !== 1'b0) $display("FAIL rst_valid_a got=%b exp=0", ifa.valid_o); else n_pass++;
        n_total++; if (ifa.ready_o !== 1'b0) $display("FAIL rst_ready_a got=%b exp=0", ifa.ready_o); else n_pass++;
        n_total++; if (ifa.data_o !== 64'h0) $display("FAIL rst_data_a got=%h exp=0", ifa.data_o); else n_pass++;
        n_total++; if (ifa.mode_o !== 1'b0) $display("FAIL rst_mode_a got=%b exp=0", ifa.mode_o); else n_pass++;
        n_total++; if (ifa.blk_cnt_o !== 4'd0) $display("FAIL rst_cnt_a got=%0d exp=0", ifa.blk_cnt_o); else n_pass++;
        n_total++; if (ifb.valid_o !== 1'b0) $display("FAIL rst_valid_b got=%b exp=0", ifb.valid_o); else n_pass++;
        n_total++; if (ifb.ready_o !== 1'b0) $display("FAIL rst_ready_b got=%b exp=0", ifb.ready_o); else n_pass++;
        n_total++; if (ifb.data_o !== 128'h0) $display("FAIL rst_data_b got=%h exp=0", ifb.data_o); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_total++; if (ifa.ready_o !== 1'b0) $display("FAIL rst_ready_pre_edge got=%b exp=0", ifa.ready_o); else n_pass++;
        @(negedge clk);
        n_total++; if (ifa.ready_o !== 1'b1) $display("FAIL rst_ready_post_a got=%b exp=1", ifa.ready_o); else n_pass++;
        n_total++; if (ifb.ready_o !== 1'b1) $display("FAIL rst_ready_post_b got=%b exp=1", ifb.ready_o); else n_pass++;
    endtask

    task automatic test_ip_single(inout int exp_cnt);
        logic        md  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [63:0] din [5] = '{P0, P1, B1, P1, B1};
        logic [63:0] dexp[5] = '{P1, P0, B58, P2, B40};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ifa.ready_i = 1'b1; ifa.valid_i = 1'b1; ifa.mode_i = md[i]; ifa.data_i = din[i];
            #1;
            n_total++; if (ifa.ready_o !== 1'b1) $display("FAIL ip_ready[%0d] got=%b exp=1", i, ifa.ready_o); else n_pass++;
            @(negedge clk);
            ifa.valid_i = 1'b0; ifa.data_i = '0; ifa.mode_i = 1'b0;
            #1;
            n_total++; if (ifa.valid_o !== 1'b0) $display("FAIL ip_latency1[%0d] got=%b exp=0", i, ifa.valid_o); else n_pass++;
            @(negedge clk);
            n_total++; if (ifa.valid_o !== 1'b1) $display("FAIL ip_latency2[%0d] got=%b exp=1", i, ifa.valid_o); else n_pass++;
            n_total++; if (ifa.data_o !== dexp[i]) $display("FAIL ip_data[%0d] got=%h exp=%h", i, ifa.data_o, dexp[i]); else n_pass++;
            n_total++; if (ifa.mode_o !== md[i]) $display("FAIL ip_mode[%0d] got=%b exp=%b", i, ifa.mode_o, md[i]); else n_pass++;
            exp_cnt = (exp_cnt + 1) % 16;
        end
        @(negedge clk);
        n_total++; if (ifa.valid_o !== 1'b0) $display("FAIL ip_drained got=%b exp=0", ifa.valid_o); else n_pass++;
        n_total++; if (ifa.blk_cnt_o !== 4'(exp_cnt)) $display("FAIL ip_cnt got=%0d exp=%0d", ifa.blk_cnt_o, exp_cnt); else n_pass++;
    endtask

    task automatic test_backpressure(inout int exp_cnt);
        logic        md  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [63:0] din [5] = '{P0, P1, ONES, 64'h0, B1};
        logic [63:0] dexp[5] = '{P1, P2, ONES, 64'h0, B58};
        int acc = 0;
        int got = 0;
        ifa.ready_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            ifa.valid_i = 1'b1; ifa.mode_i = md[acc]; ifa.data_i = din[acc];
            #1;
            if (ifa.valid_i && ifa.ready_o) acc++;
        end
        n_total++; if (acc != 2) $display("FAIL bp_accepted got=%0d exp=2", acc); else n_pass++;
        n_total++; if (ifa.ready_o !== 1'b0) $display("FAIL bp_ready_low got=%b exp=0", ifa.ready_o); else n_pass++;
        n_total++; if (ifa.valid_o !== 1'b1) $display("FAIL bp_valid_held got=%b exp=1", ifa.valid_o); else n_pass++;
        n_total++; if (ifa.data_o !== P1) $display("FAIL bp_data_held got=%h exp=%h", ifa.data_o, P1); else n_pass++;
        @(negedge clk);
        n_total++; if (ifa.data_o !== P1 || ifa.mode_o !== 1'b0) $display("FAIL bp_data_stable got=%h/%b exp=%h/0", ifa.data_o, ifa.mode_o, P1); else n_pass++;
        for (int c = 0; c < 30 && got < 5; c++) begin
            if (c != 0) @(negedge clk);
            ifa.ready_i = 1'b1;
            if (acc < 5) begin
                ifa.valid_i = 1'b1; ifa.mode_i = md[acc]; ifa.data_i = din[acc];
            end else begin
                ifa.valid_i = 1'b0; ifa.data_i = '0;
            end
            #1;
            if (c == 0) begin
                n_total++; if (ifa.ready_o !== 1'b1) $display("FAIL bp_full_ready got=%b exp=1", ifa.ready_o); else n_pass++;
            end
            if (ifa.valid_o && ifa.ready_i) begin
                n_total++; if (ifa.data_o !== dexp[got]) $display("FAIL bp_data[%0d] got=%h exp=%h", got, ifa.data_o, dexp[got]); else n_pass++;
                n_total++; if (ifa.mode_o !== md[got]) $display("FAIL bp_mode[%0d] got=%b exp=%b", got, ifa.mode_o, md[got]); else n_pass++;
                got++;
                exp_cnt = (exp_cnt + 1) % 16;
            end
            if (ifa.valid_i && ifa.ready_o) acc++;
        end
        n_total++; if (got != 5) $display("FAIL bp_drain_count got=%0d exp=5", got); else n_pass++;
        @(negedge clk);
        ifa.valid_i = 1'b0;
        #1;
        n_total++; if (ifa.valid_o !== 1'b0) $display("FAIL bp_no_dup got=%b exp=0", ifa.valid_o); else n_pass++;
        n_total++; if (ifa.blk_cnt_o !== 4'(exp_cnt)) $display("FAIL bp_cnt got=%0d exp=%0d", ifa.blk_cnt_o, exp_cnt); else n_pass++;
    endtask

    task automatic test_counter_wrap();
        int acc = 0;
        int got = 0;
        @(negedge clk);
        rst_n = 1'b0; ifa.valid_i = 1'b0; ifa.ready_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (ifa.blk_cnt_o !== 4'd0) $display("FAIL wrap_cnt_start got=%0d exp=0", ifa.blk_cnt_o); else n_pass++;
        for (int c = 0; c < 60 && got < 17; c++) begin
            if (c != 0) @(negedge clk);
            ifa.valid_i = (acc < 17); ifa.mode_i = 1'b0; ifa.data_i = P0;
            #1;
            if (ifa.valid_o && ifa.ready_i) got++;
            if (ifa.valid_i && ifa.ready_o) acc++;
        end
        @(negedge clk);
        ifa.valid_i = 1'b0;
        #1;
        n_total++; if (got != 17) $display("FAIL wrap_transfers got=%0d exp=17", got); else n_pass++;
        n_total++; if (ifa.blk_cnt_o !== 4'd1) $display("FAIL wrap_cnt got=%0d exp=1", ifa.blk_cnt_o); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        int acc = 0;
        int spurious = 0;
        ifa.ready_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ifa.valid_i = (acc < 2); ifa.mode_i = 1'b0; ifa.data_i = (acc == 0) ? P1 : ONES;
            #1;
            if (ifa.valid_i && ifa.ready_o) acc++;
        end
        n_total++; if (acc != 2 || ifa.valid_o !== 1'b1) $display("FAIL mid_inflight got=%0d/%b exp=2/1", acc, ifa.valid_o); else n_pass++;
        @(negedge clk);
        ifa.valid_i = 1'b0; ifa.ready_i = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        n_total++; if (ifa.valid_o !== 1'b0) $display("FAIL mid_valid got=%b exp=0", ifa.valid_o); else n_pass++;
        n_total++; if (ifa.blk_cnt_o !== 4'd0) $display("FAIL mid_cnt got=%0d exp=0", ifa.blk_cnt_o); else n_pass++;
        n_total++; if (ifa.ready_o !== 1'b0) $display("FAIL mid_ready got=%b exp=0", ifa.ready_o); else n_pass++;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (ifa.valid_o !== 1'b0) spurious++;
        end
        n_total++; if (spurious != 0) $display("FAIL mid_dropped got=%0d exp=0", spurious); else n_pass++;
        n_total++; if (ifa.blk_cnt_o !== 4'd0) $display("FAIL mid_cnt_after got=%0d exp=0", ifa.blk_cnt_o); else n_pass++;
        n_total++; if (ifa.ready_o !== 1'b1) $display("FAIL mid_ready_after got=%b exp=1", ifa.ready_o); else n_pass++;
    endtask

    task automatic test_lanes();
        logic         md  [2] = '{1'b0, 1'b1};
        logic [127:0] din [2] = '{{P0, P1}, {P1, P2}};
        logic [127:0] dexp[2] = '{{P1, P2}, {P0, P1}};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ifb.ready_i = 1'b1; ifb.valid_i = 1'b1; ifb.mode_i = md[i]; ifb.data_i = din[i];
            for (int c = 1; c <= 2; c++) begin
                @(negedge clk);
                ifb.valid_i = 1'b0; ifb.data_i = '0;
                #1;
                n_total++; if (ifb.valid_o !== 1'b0) $display("FAIL lanes_latency[%0d.%0d] got=%b exp=0", i, c, ifb.valid_o); else n_pass++;
            end
            @(negedge clk);
            n_total++; if (ifb.valid_o !== 1'b1) $display("FAIL lanes_valid[%0d] got=%b exp=1", i, ifb.valid_o); else n_pass++;
            n_total++; if (ifb.data_o !== dexp[i]) $display("FAIL lanes_data[%0d] got=%h exp=%h", i, ifb.data_o, dexp[i]); else n_pass++;
            n_total++; if (ifb.mode_o !== md[i]) $display("FAIL lanes_mode[%0d] got=%b exp=%b", i, ifb.mode_o, md[i]); else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        // Block kinds: A {P0,P1}/0  B {P1,P2}/1  C {ONES,0}/0  D {0,B1}/1  E {P1,P0}/0
        logic [127:0] in_t [10] = '{{P0, P1}, {P1, P2}, {P1, P0}, {64'h0, B1}, {ONES, 64'h0},
                                    {P1, P2}, {P0, P1}, {64'h0, B1}, {P1, P0}, {P1, P2}};
        logic [127:0] exp_t[10] = '{{P1, P2}, {P0, P1}, {P2, P1}, {64'h0, B58}, {ONES, 64'h0},
                                    {P0, P1}, {P1, P2}, {64'h0, B58}, {P2, P1}, {P0, P1}};
        logic         md_t [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int acc = 0;
        int got = 0;
        int last_acc = -1;
        int first_out = -1;
        int last_out = -1;
        for (int c = 0; c < 40 && got < 10; c++) begin
            @(negedge clk);
            ifb.ready_i = 1'b1;
            if (acc < 10) begin
                ifb.valid_i = 1'b1; ifb.mode_i = md_t[acc]; ifb.data_i = in_t[acc];
            end else begin
                ifb.valid_i = 1'b0; ifb.data_i = '0;
            end
            #1;
            if (ifb.valid_o && ifb.ready_i) begin
                n_total++; if (ifb.data_o !== exp_t[got]) $display("FAIL b2b_data[%0d] got=%h exp=%h", got, ifb.data_o, exp_t[got]); else n_pass++;
                n_total++; if (ifb.mode_o !== md_t[got]) $display("FAIL b2b_mode[%0d] got=%b exp=%b", got, ifb.mode_o, md_t[got]); else n_pass++;
                if (first_out < 0) first_out = c;
                last_out = c;
                got++;
            end
            if (ifb.valid_i && ifb.ready_o) begin
                acc++;
                last_acc = c;
            end
        end
        n_total++; if (got != 10) $display("FAIL b2b_count got=%0d exp=10", got); else n_pass++;
        n_total++; if (last_acc != 9) $display("FAIL b2b_accept_rate got=%0d exp=9", last_acc); else n_pass++;
        n_total++; if (first_out != 3) $display("FAIL b2b_latency got=%0d exp=3", first_out); else n_pass++;
        n_total++; if (last_out - first_out != 9) $display("FAIL b2b_out_rate got=%0d exp=9", last_out - first_out); else n_pass++;
        @(negedge clk);
        ifb.valid_i = 1'b0;
        #1;
        n_total++; if (ifb.blk_cnt_o !== 16'd12) $display("FAIL b2b_cnt got=%0d exp=12", ifb.blk_cnt_o); else n_pass++;
    endtask

    initial begin
        int cnt_a;
        cnt_a = 0;
        test_reset();
        test_ip_single(cnt_a);
        test_backpressure(cnt_a);
        test_counter_wrap();
        test_reset_midflight();
        test_lanes();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
